muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequential controller for the HI/LO multiply/divide resource of the MiniSys-1A CPU. It accepts the decoded `op_mult/op_multu/op_div/op_divu/op_mfhi/op_mflo/op_mthi/op_mtlo` strobes and `rs`/`rt` operands from the execute stage. It runs a 32-iteration shift-add multiply or restoring divide, applies sign fix-up, and owns the HI and LO registers. It raises a pipeline stall whenever a HI/LO-touching instruction arrives while an operation is still in flight.

## Interface
- `WIDTH`, default 32: operand width. The iteration count equals WIDTH.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_mult`, `op_multu`, `op_div`, `op_divu`  in  1 each  start strobes, already qualified by valid instruction.
- `op_mfhi`, `op_mflo`, `op_mthi`, `op_mtlo`  in  1 each  HI/LO move strobes.
- `rs_data`  in  WIDTH  dividend / multiplicand / mt source.
- `rt_data`  in  WIDTH  divisor / multiplier.
- `busy`  out  1  an operation is in flight (registered).
- `stall`  out  1  combinational; freeze the issuing stage.
- `done`  out  1  registered one-cycle pulse: new HI/LO are visible.
- `mf_data`  out  WIDTH  combinational; HI if `op_mfhi`, LO if `op_mflo`, else 0.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States are IDLE, RUN and FIX.
- **Reset values:** state IDLE; `busy`, `done`, `hi`, `lo` and iteration count are all 0.
- **Reset mid-operation:** the operation is discarded and reset values are applied at that edge.
- **IDLE:**
  - On a start strobe, latch |rs| and |rt| (raw values for unsigned ops), the op type and the result sign flags. Clear the accumulator, count=0, go to RUN.
  - `op_mthi` / `op_mtlo` write `rs_data` to HI / LO at the edge.
  - Strobes are one-hot by contract. If several are asserted, priority is div > divu > mult > multu > mthi > mtlo. mf reads never conflict.
- **RUN:**
  - One iteration per cycle. Multiply is shift-add into a 2·WIDTH accumulator. Divide is restoring: shift the remainder left, subtract, set the quotient bit.
  - After iteration WIDTH-1 (count wraps at WIDTH), go to FIX.
- **FIX:**
  - Signed mult: negate the 64-bit product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write HI = upper product / remainder, LO = lower product / quotient. Go to IDLE; `done` is high the next cycle.
- **Divide by zero (div or divu):** iterations still run in full. The result is forced to HI = `rs_data` as latched, LO = all ones, with no sign fix-up.
- **|−2^31|:** represented as unsigned 0x80000000. No overflow special case; `div 0x80000000 / 0xFFFFFFFF` yields LO=0x80000000, HI=0.
- **`stall`:** `busy` AND (any of the eight strobes). Strobes presented while `stall`=1 are ignored; the pipeline re-presents them.
- **mt while idle:** an mt in IDLE overwrites only its own register. A subsequent start overwrites both.

## Timing
- Start accepted at edge ending cycle T.
- RUN occupies T+1..T+32. FIX is T+33 and writes HI/LO at the end of T+33.
- `busy` is high T+1..T+33 (33 cycles). `done` and the new `hi`/`lo` are visible in T+34.
- A new start may be accepted in T+34, so back-to-back throughput is 1 op per 34 cycles.
- mfhi/mflo in IDLE: `mf_data` is valid in the same cycle.
- mfhi/mflo during `busy`: stall until T+33 inclusive; released in T+34 with the new value.
- mthi/mtlo: write at the accepting edge; visible on `hi`/`lo` the next cycle.

## Test plan
- `multu` 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `busy` high exactly 33 cycles; `done` pulses at T+34.
- `mult` −3 × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; `mult` 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- `div` −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; `divu` 100 / 7 → LO=14, HI=2.
- `div` 0x12345678 / 0 → HI=0x12345678, LO=0xFFFFFFFF, with the same 34-cycle latency.
- `mflo` presented at T+5 of a divide → `stall`=1 T+5..T+33; at T+34 `stall`=0 and `mf_data` equals the new LO.
- Assert `reset` at T+10 of a multiply → next cycle `busy`=0, `hi`=`lo`=0. Then `mthi` 0xA5A5A5A5 followed by `mfhi` returns 0xA5A5A5A5 with `stall`=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO multiply/divide controller for the MiniSys-1A execute stage.
// One shift-add multiply or restoring divide step per cycle on operand magnitudes,
// followed by a single sign fix-up cycle that writes HI and LO.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             op_mult,
   input  logic             op_multu,
   input  logic             op_div,
   input  logic             op_divu,
   input  logic             op_mfhi,
   input  logic             op_mflo,
   input  logic             op_mthi,
   input  logic             op_mtlo,
   input  logic [WIDTH-1:0] rs_data,
   input  logic [WIDTH-1:0] rt_data,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] mf_data,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   // Magnitude of a value; unsigned operations pass the raw bits through.
   // The most negative value maps onto itself, which reads correctly as unsigned.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
      logic [WIDTH-1:0] r;
      if (is_signed && v[WIDTH-1]) begin
         r = (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   logic [1:0]         state_q,    state_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic [WIDTH-1:0]   hi_q,       hi_d;
   logic [WIDTH-1:0]   lo_q,       lo_d;
   logic [CW-1:0]      cnt_q,      cnt_d;
   logic [WIDTH-1:0]   opa_q,      opa_d;      // |rs|: multiplicand / dividend bits
   logic [WIDTH-1:0]   opb_q,      opb_d;      // |rt|: multiplier bits / divisor
   logic [WIDTH-1:0]   rs_lat_q,   rs_lat_d;   // raw rs kept for the divide-by-zero result
   logic               is_div_q,   is_div_d;
   logic               neg_res_q,  neg_res_d;  // product / quotient must be negated
   logic               neg_rem_q,  neg_rem_d;  // remainder must be negated
   logic [2*WIDTH-1:0] acc_q,      acc_d;

   logic               start_s;
   logic               start_signed_s;
   logic               start_div_s;
   logic [WIDTH:0]     mul_sum_s;
   logic [WIDTH:0]     div_remsh_s;
   logic [WIDTH:0]     div_diff_s;
   logic [WIDTH-1:0]   quo_fix_s;
   logic [WIDTH-1:0]   rem_fix_s;
   logic [2*WIDTH-1:0] prod_fix_s;

   // Decode the start strobes with div > divu > mult > multu priority.
   always_comb begin
      start_s        = op_div | op_divu | op_mult | op_multu;
      start_div_s    = op_div | op_divu;
      start_signed_s = op_div | (~op_divu & op_mult);
   end

   // Datapath for one iteration and for the final sign fix-up.
   always_comb begin
      mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      if (opb_q[0]) begin
         mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opa_q};
      end else begin
         mul_sum_s = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      end
      div_remsh_s = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
      div_diff_s  = div_remsh_s - {1'b0, opb_q};
      if (neg_res_q) begin
         quo_fix_s  = (~acc_q[WIDTH-1:0]) + {{(WIDTH-1){1'b0}}, 1'b1};
         prod_fix_s = (~acc_q) + {{(2*WIDTH-1){1'b0}}, 1'b1};
      end else begin
         quo_fix_s  = acc_q[WIDTH-1:0];
         prod_fix_s = acc_q;
      end
      if (neg_rem_q) begin
         rem_fix_s = (~acc_q[2*WIDTH-1:WIDTH]) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         rem_fix_s = acc_q[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state logic for the IDLE / RUN / FIX sequencer and HI/LO.
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      rs_lat_d  = rs_lat_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      acc_d     = acc_q;
      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               opa_d     = magnitude(rs_data, start_signed_s);
               opb_d     = magnitude(rt_data, start_signed_s);
               rs_lat_d  = rs_data;
               is_div_d  = start_div_s;
               neg_res_d = start_signed_s & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
               neg_rem_d = start_signed_s & rs_data[WIDTH-1];
               acc_d     = '0;
               cnt_d     = '0;
               state_d   = S_RUN;
               busy_d    = 1'b1;
            end else if (op_mthi) begin
               hi_d = rs_data;
            end else if (op_mtlo) begin
               lo_d = rs_data;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (is_div_q) begin
               // Restoring step: keep the trial difference only if it did not borrow.
               if (!div_diff_s[WIDTH]) begin
                  acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d = {div_remsh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               end
               opa_d = {opa_q[WIDTH-2:0], 1'b0};
            end else begin
               // Shift-add step: conditionally add, then shift the whole product right.
               acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
               opb_d = {1'b0, opb_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH - 1)) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end else begin
               cnt_d   = cnt_q + CW'(1);
               state_d = S_RUN;
            end
         end
         S_FIX: begin
            if (is_div_q) begin
               // The divisor register is untouched during a divide, so it still holds |rt|.
               if (opb_q == '0) begin
                  hi_d = rs_lat_q;
                  lo_d = '1;
               end else begin
                  hi_d = rem_fix_s;
                  lo_d = quo_fix_s;
               end
            end else begin
               hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
               lo_d = prod_fix_s[WIDTH-1:0];
            end
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset; reset discards any operation in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         opa_q     <= '0;
         opb_q     <= '0;
         rs_lat_q  <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         acc_q     <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         rs_lat_q  <= rs_lat_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         acc_q     <= acc_d;
      end
   end

   // HI/LO read port and stall request toward the issuing stage.
   always_comb begin
      stall = busy_q & (op_mult | op_multu | op_div | op_divu |
                        op_mfhi | op_mflo | op_mthi | op_mtlo);
      if (op_mfhi) begin
         mf_data = hi_q;
      end else if (op_mflo) begin
         mf_data = lo_q;
      end else begin
         mf_data = '0;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized scoreboard bench for muldiv_ctrl with an arithmetic reference model.
module tb_muldiv_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        op_mult, op_multu, op_div, op_divu;
   logic        op_mfhi, op_mflo, op_mthi, op_mtlo;
   logic [31:0] rs_data, rt_data;
   logic        busy, stall, done;
   logic [31:0] mf_data, hi, lo;

   logic [63:0] exp_q[$];
   logic [63:0] mon_e;
   logic [31:0] m_hi, m_lo;
   int          n_chk  = 0;
   int          n_fail = 0;

   always #5 clock = ~clock;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .op_mult(op_mult), .op_multu(op_multu), .op_div(op_div), .op_divu(op_divu),
      .op_mfhi(op_mfhi), .op_mflo(op_mflo), .op_mthi(op_mthi), .op_mtlo(op_mtlo),
      .rs_data(rs_data), .rt_data(rt_data),
      .busy(busy), .stall(stall), .done(done),
      .mf_data(mf_data), .hi(hi), .lo(lo)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   // Reference: kind 0 mult, 1 multu, 2 div, 3 divu; returns {HI, LO}.
   function automatic logic [63:0] model(input int kind, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (kind)
         0: res = 64'(sa * sb);
         1: res = {32'h0, a} * {32'h0, b};
         2: begin
            if (b == 32'h0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Monitor: each done pulse consumes one expected result.
   always @(negedge clock) begin
      if (!reset && done === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'(0));
         end else begin
            mon_e = exp_q.pop_front();
            chk("result_hi", 64'(hi), 64'(mon_e[63:32]));
            chk("result_lo", 64'(lo), 64'(mon_e[31:0]));
         end
      end
   end

   task automatic clear_strobes();
      op_mult = 1'b0; op_multu = 1'b0; op_div = 1'b0; op_divu = 1'b0;
      op_mfhi = 1'b0; op_mflo  = 1'b0; op_mthi = 1'b0; op_mtlo = 1'b0;
   endtask

   // Issue one operation; optionally hold mflo from cycle T+mf_at to exercise the stall.
   task automatic run_op(input int kind, input logic [31:0] a, input logic [31:0] b, input int mf_at);
      logic [63:0] r;
      int          busy_n;
      int          done_at;
      @(negedge clock);
      rs_data = a;
      rt_data = b;
      op_mult  = (kind == 0);
      op_multu = (kind == 1);
      op_div   = (kind == 2);
      op_divu  = (kind == 3);
      r = model(kind, a, b);
      exp_q.push_back(r);
      @(posedge clock);
      #1;
      clear_strobes();
      rs_data = $urandom;
      rt_data = $urandom;
      busy_n  = 0;
      done_at = 0;
      for (int k = 1; k <= 34; k++) begin
         if (mf_at > 0 && k == mf_at) op_mflo = 1'b1;
         @(negedge clock);
         if (busy === 1'b1) busy_n++;
         if (done === 1'b1) done_at = k;
         if (mf_at > 0 && k >= mf_at) begin
            if (k <= 33) begin
               chk("stall_hold", 64'(stall), 64'(1));
            end else begin
               chk("stall_release", 64'(stall), 64'(0));
               chk("mf_new_lo", 64'(mf_data), 64'(r[31:0]));
            end
         end
         @(posedge clock);
         #1;
      end
      op_mflo = 1'b0;
      chk("busy_cycles", 64'(busy_n), 64'(33));
      chk("done_cycle", 64'(done_at), 64'(34));
      m_hi = r[63:32];
      m_lo = r[31:0];
   endtask

   task automatic plan(input string name, input logic [31:0] hi_e, input logic [31:0] lo_e);
      chk({name, "_hi"}, 64'(hi), 64'(hi_e));
      chk({name, "_lo"}, 64'(lo), 64'(lo_e));
   endtask

   task automatic do_mt(input bit sel_hi, input logic [31:0] v);
      @(negedge clock);
      rs_data = v;
      op_mthi = sel_hi;
      op_mtlo = !sel_hi;
      @(posedge clock);
      #1;
      clear_strobes();
      if (sel_hi) m_hi = v;
      else        m_lo = v;
      @(negedge clock);
      chk("mt_hi", 64'(hi), 64'(m_hi));
      chk("mt_lo", 64'(lo), 64'(m_lo));
   endtask

   task automatic do_mf(input bit sel_hi);
      @(negedge clock);
      op_mfhi = sel_hi;
      op_mflo = !sel_hi;
      #1;
      chk("mf_stall", 64'(stall), 64'(0));
      chk("mf_data", 64'(mf_data), sel_hi ? 64'(m_hi) : 64'(m_lo));
      clear_strobes();
   endtask

   initial begin
      int          kind;
      int          sel;
      logic [31:0] a, b;
      clear_strobes();
      rs_data = 32'h0;
      rt_data = 32'h0;
      reset   = 1'b1;
      m_hi    = 32'h0;
      m_lo    = 32'h0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      chk("reset_hi", 64'(hi), 64'(0));
      chk("reset_lo", 64'(lo), 64'(0));
      chk("reset_stall", 64'(stall), 64'(0));
      chk("reset_mf", 64'(mf_data), 64'(0));

      run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      plan("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
      run_op(0, 32'hFFFF_FFFD, 32'd7, 0);
      plan("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op(0, 32'h8000_0000, 32'h8000_0000, 0);
      plan("mult_min", 32'h4000_0000, 32'h0000_0000);
      run_op(2, 32'hFFFF_FFF9, 32'd2, 5);
      plan("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op(3, 32'd100, 32'd7, 0);
      plan("divu_small", 32'd2, 32'd14);
      run_op(2, 32'h1234_5678, 32'h0, 0);
      plan("div_zero", 32'h1234_5678, 32'hFFFF_FFFF);
      run_op(2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      plan("div_min", 32'h0000_0000, 32'h8000_0000);
      run_op(3, 32'hDEAD_BEEF, 32'h0, 0);

      do_mt(1'b1, 32'h1111_1111);
      do_mt(1'b0, 32'h2222_2222);
      do_mf(1'b1);
      do_mf(1'b0);

      for (int i = 0; i < 24; i++) begin
         kind = $urandom_range(0, 3);
         a    = $urandom;
         if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
         sel = $urandom_range(0, 7);
         case (sel)
            0:       b = 32'h0;
            1:       b = $urandom_range(1, 15);
            2:       b = 32'hFFFF_FFFF;
            3:       b = 32'h8000_0000;
            default: b = $urandom;
         endcase
         run_op(kind, a, b, 0);
         if ((i % 6) == 5) begin
            do_mt(i[0], $urandom);
            do_mf(1'b1);
            do_mf(1'b0);
         end
      end

      // Reset during a multiply: nothing may complete and HI/LO return to zero.
      @(negedge clock);
      rs_data = 32'd5;
      rt_data = 32'd9;
      op_mult = 1'b1;
      @(posedge clock);
      #1;
      clear_strobes();
      repeat (9) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      m_hi  = 32'h0;
      m_lo  = 32'h0;
      @(negedge clock);
      chk("midreset_busy", 64'(busy), 64'(0));
      chk("midreset_hi", 64'(hi), 64'(0));
      chk("midreset_lo", 64'(lo), 64'(0));
      do_mt(1'b1, 32'hA5A5_A5A5);
      do_mf(1'b1);
      repeat (40) @(negedge clock);
      chk("midreset_no_done", 64'(exp_q.size()), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
